// File: rtl/seletor_modo_pkg.sv
// Shared constants for the game-mode selector: FSM state codes, output codes
// and the button decoding helpers used by the FSM.
package seletor_modo_pkg;

  localparam logic [2:0] ST_INICIAL          = 3'd0;
  localparam logic [2:0] ST_ESPERA_NIVEL     = 3'd1;
  localparam logic [2:0] ST_REGISTRA_NIVEL   = 3'd2;
  localparam logic [2:0] ST_ESPERA_MEMORIA   = 3'd3;
  localparam logic [2:0] ST_REGISTRA_MEMORIA = 3'd4;
  localparam logic [2:0] ST_PRONTO           = 3'd5;

  localparam logic [3:0] SEL_INVALID = 4'b1111;

  localparam logic [1:0] NIVEL_FACIL   = 2'b00;
  localparam logic [1:0] NIVEL_MEDIO   = 2'b01;
  localparam logic [1:0] NIVEL_DIFICIL = 2'b10;

  localparam logic [1:0] MEM_FACIL   = 2'b00;
  localparam logic [1:0] MEM_MEDIO   = 2'b01;
  localparam logic [1:0] MEM_DIFICIL = 2'b10;
  localparam logic [1:0] MEM_CUSTOM  = 2'b11;

  typedef struct packed {
    logic [1:0] nivel;
    logic [1:0] memoria;
  } modo_t;

  function automatic logic eh_onehot(input logic [3:0] b);
    return b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  // Only three levels exist, so button 3 is not a legal level choice.
  function automatic logic nivel_valido(input logic [3:0] b);
    return b inside {4'b0001, 4'b0010, 4'b0100};
  endfunction

  function automatic logic [1:0] indice_botao(input logic [3:0] b);
    case (b)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seletor_modo_if.sv
// Control and status bundle between the selector and the game controller.
interface seletor_modo_if;
  logic       iniciar;
  logic [3:0] botoes;
  logic [3:0] sel;
  logic [1:0] nivel;
  logic [1:0] memoria;
  logic       pronto;
  logic       timeout;
  logic [2:0] db_estado;

  modport master (
    output iniciar, botoes,
    input  sel, nivel, memoria, pronto, timeout, db_estado
  );

  modport slave (
    input  iniciar, botoes,
    output sel, nivel, memoria, pronto, timeout, db_estado
  );
endinterface

// File: rtl/seletor_modo_contador_timeout.sv
// Idle-cycle counter for the wait states: counts 0..M-1 while enabled and
// flags the last count so the FSM can abort on the same cycle.
module contador_timeout #(
  parameter int M = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = $clog2(M);

  logic [W-1:0] r_contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (zera) begin
      // NOTE: non-blocking assignment so the register takes its new value only after every process has sampled the old one.
      r_contagem <= '0;
    end else if (conta) begin
      if (r_contagem == W'(M - 1)) r_contagem <= '0;
      else                         r_contagem <= r_contagem + 1'b1;
    end
  end

  assign fim = (r_contagem == W'(M - 1));

endmodule

// File: rtl/seletor_modo.sv
// Game-mode selector: walks the player through level then memory choice and
// presents a registered mode code, aborting back to idle after TIMEOUT idle cycles.
module seletor_modo
  import seletor_modo_pkg::*;
#(
  parameter int TIMEOUT = 5000
) (
  input  logic          clock,
  input  logic          reset,
  seletor_modo_if.slave bus
);

  logic [2:0] r_estado;
  logic [2:0] w_prox;
  logic [1:0] r_indice;
  logic [1:0] r_nivel;
  logic [1:0] r_memoria;
  logic [3:0] r_sel;
  logic       r_pronto;
  logic       r_timeout;

  logic       w_espera;
  logic       w_aceita;
  logic       w_fim;
  logic       w_aborta;
  modo_t      w_modo;

  assign w_espera = (r_estado == ST_ESPERA_NIVEL) || (r_estado == ST_ESPERA_MEMORIA);
  assign w_aceita = ((r_estado == ST_ESPERA_NIVEL)   && nivel_valido(bus.botoes)) ||
                    ((r_estado == ST_ESPERA_MEMORIA) && eh_onehot(bus.botoes));
  // A press landing on the last idle cycle still wins over the abort.
  assign w_aborta = w_espera && w_fim && !w_aceita;
  assign w_modo   = '{nivel: r_nivel, memoria: r_indice};

  // Counter idles at zero outside the wait states, so each entry starts fresh.
  contador_timeout #(.M(TIMEOUT)) u_contador (
    .clock (clock),
    .reset (reset),
    .zera  (!w_espera),
    .conta (w_espera),
    .fim   (w_fim)
  );

  always_comb begin
    // NOTE: default assignment first so every path drives w_prox and no latch is inferred.
    w_prox = r_estado;
    case (r_estado)
      ST_INICIAL:          if (bus.iniciar) w_prox = ST_ESPERA_NIVEL;
      ST_ESPERA_NIVEL: begin
        if (w_aceita)   w_prox = ST_REGISTRA_NIVEL;
        else if (w_fim) w_prox = ST_INICIAL;
      end
      ST_REGISTRA_NIVEL:   w_prox = ST_ESPERA_MEMORIA;
      ST_ESPERA_MEMORIA: begin
        if (w_aceita)   w_prox = ST_REGISTRA_MEMORIA;
        else if (w_fim) w_prox = ST_INICIAL;
      end
      ST_REGISTRA_MEMORIA: w_prox = ST_PRONTO;
      ST_PRONTO:           if (bus.iniciar) w_prox = ST_ESPERA_NIVEL;
      default:             w_prox = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= ST_INICIAL;
      r_indice  <= 2'd0;
      r_nivel   <= NIVEL_FACIL;
      r_memoria <= MEM_FACIL;
      r_sel     <= SEL_INVALID;
      r_pronto  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      r_timeout <= w_aborta;
      // Buttons are single-cycle pulses, so the index is captured at acceptance.
      if (w_aceita) r_indice <= indice_botao(bus.botoes);
      case (r_estado)
        ST_REGISTRA_NIVEL: r_nivel <= r_indice;
        ST_REGISTRA_MEMORIA: begin
          r_memoria <= r_indice;
          r_sel     <= w_modo;
          r_pronto  <= 1'b1;
        end
        ST_PRONTO: begin
          if (bus.iniciar) begin
            r_sel    <= SEL_INVALID;
            r_pronto <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sel       = r_sel;
  assign bus.nivel     = r_nivel;
  assign bus.memoria   = r_memoria;
  assign bus.pronto    = r_pronto;
  assign bus.timeout   = r_timeout;
  assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_seletor_modo.sv
// Self-checking bench for seletor_modo: directed scenarios plus random
// button/start traffic, all compared against a cycle-stepped behavioural model.
module tb_seletor_modo;
  import seletor_modo_pkg::*;

  localparam int TIMEOUT = 8;

  logic clock;
  logic reset;

  seletor_modo_if bus ();

  seletor_modo #(.TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests;
  int n_fail;
  int n_pulsos;

  // Behavioural model: phase, idle cycles spent in the current wait, pending index.
  logic [2:0] m_st;
  int         m_idle;
  int         m_idx;
  logic [1:0] m_nivel;
  logic [1:0] m_mem;
  logic [3:0] m_sel;
  logic       m_pronto;
  logic       m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st     = ST_INICIAL;
    m_idle   = 0;
    m_idx    = 0;
    m_nivel  = 2'b00;
    m_mem    = 2'b00;
    m_sel    = 4'b1111;
    m_pronto = 1'b0;
    m_to     = 1'b0;
  endtask

  task automatic model_step(input logic ini, input logic [3:0] bot);
    bit unico;
    bit aceito;
    unico  = ($countones(bot) == 1);
    m_to   = 1'b0;
    case (m_st)
      ST_INICIAL: begin
        if (ini) begin m_st = ST_ESPERA_NIVEL; m_idle = 0; end
      end
      ST_ESPERA_NIVEL, ST_ESPERA_MEMORIA: begin
        aceito = unico && ((m_st == ST_ESPERA_MEMORIA) || (bot != 4'b1000));
        if (aceito) begin
          m_idx = $clog2(bot);
          m_st  = (m_st == ST_ESPERA_NIVEL) ? ST_REGISTRA_NIVEL : ST_REGISTRA_MEMORIA;
        end else if (m_idle == TIMEOUT - 1) begin
          m_st     = ST_INICIAL;
          m_to     = 1'b1;
          m_sel    = 4'b1111;
          m_pronto = 1'b0;
        end else begin
          m_idle++;
        end
      end
      ST_REGISTRA_NIVEL: begin
        m_nivel = m_idx[1:0];
        m_st    = ST_ESPERA_MEMORIA;
        m_idle  = 0;
      end
      ST_REGISTRA_MEMORIA: begin
        m_mem    = m_idx[1:0];
        m_sel    = {m_nivel, m_mem};
        m_pronto = 1'b1;
        m_st     = ST_PRONTO;
      end
      ST_PRONTO: begin
        if (ini) begin
          m_st     = ST_ESPERA_NIVEL;
          m_idle   = 0;
          m_sel    = 4'b1111;
          m_pronto = 1'b0;
        end
      end
      default: m_st = ST_INICIAL;
    endcase
  endtask

  task automatic cmp_all(input string w);
    check({w, ":estado"},  32'(bus.db_estado), 32'(m_st));
    check({w, ":sel"},     32'(bus.sel),       32'(m_sel));
    check({w, ":nivel"},   32'(bus.nivel),     32'(m_nivel));
    check({w, ":memoria"}, 32'(bus.memoria),   32'(m_mem));
    check({w, ":pronto"},  32'(bus.pronto),    32'(m_pronto));
    check({w, ":timeout"}, 32'(bus.timeout),   32'(m_to));
  endtask

  // Inputs are held for exactly one rising edge, outputs compared 1 ns after it.
  task automatic step(input logic ini, input logic [3:0] bot, input string w);
    bus.iniciar = ini;
    bus.botoes  = bot;
    @(posedge clock);
    model_step(ini, bot);
    #1;
    bus.iniciar = 1'b0;
    bus.botoes  = 4'b0000;
    cmp_all(w);
    if (bus.timeout === 1'b1) n_pulsos++;
  endtask

  // Reset pulse placed mid-cycle; outputs must settle before the next edge.
  task automatic async_reset(input string w);
    #2 reset = 1'b1;
    #1;
    model_reset();
    cmp_all(w);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ini;
    logic [3:0] bot;
    n_tests  = 0;
    n_fail   = 0;
    n_pulsos = 0;
    bus.iniciar = 1'b0;
    bus.botoes  = 4'b0000;
    reset = 1'b0;

    #2 reset = 1'b1;
    #1;
    model_reset();
    cmp_all("reset");
    check("reset:sel_const", 32'(bus.sel), 32'hF);
    #4 reset = 1'b0;

    // Level medium, memory custom -> 0111 two cycles after the memory press.
    step(1'b1, 4'b0000, "r31_ini");
    step(1'b0, 4'b0010, "r31_niv");
    step(1'b0, 4'b0000, "r31_rn");
    step(1'b0, 4'b1000, "r31_mem");
    check("r31_pronto_n1", 32'(bus.pronto), 32'd0);
    step(1'b0, 4'b0000, "r31_fim");
    check("r31_sel", 32'(bus.sel), 32'h7);
    check("r31_pronto", 32'(bus.pronto), 32'd1);

    // Reach 1011, then restart from PRONTO.
    step(1'b1, 4'b0000, "r36_ini");
    step(1'b0, 4'b0100, "r36_niv");
    step(1'b0, 4'b0000, "r36_rn");
    step(1'b0, 4'b1000, "r36_mem");
    step(1'b0, 4'b0000, "r36_pr");
    check("r36_sel_pronto", 32'(bus.sel), 32'hB);
    step(1'b1, 4'b0101, "r36_reini");
    check("r36_sel", 32'(bus.sel), 32'hF);
    check("r36_pronto", 32'(bus.pronto), 32'd0);
    check("r36_estado", 32'(bus.db_estado), 32'(ST_ESPERA_NIVEL));

    // Illegal level presses and a stray iniciar are ignored.
    step(1'b1, 4'b1000, "r32_b1000");
    check("r32_ign1", 32'(bus.db_estado), 32'(ST_ESPERA_NIVEL));
    step(1'b0, 4'b0011, "r32_b0011");
    check("r32_ign2", 32'(bus.db_estado), 32'(ST_ESPERA_NIVEL));
    step(1'b0, 4'b0100, "r32_niv");
    step(1'b0, 4'b0000, "r32_rn");
    step(1'b0, 4'b0001, "r32_mem");
    step(1'b0, 4'b0000, "r32_fim");
    check("r32_sel", 32'(bus.sel), 32'h8);

    // Eight idle cycles abort with a single timeout pulse.
    step(1'b1, 4'b0000, "r33_ini");
    n_pulsos = 0;
    repeat (TIMEOUT - 1) step(1'b0, 4'b0000, "r33_idle");
    check("r33_no_early", 32'(bus.timeout), 32'd0);
    step(1'b0, 4'b0000, "r33_last");
    check("r33_pulse", 32'(bus.timeout), 32'd1);
    check("r33_estado", 32'(bus.db_estado), 32'(ST_INICIAL));
    check("r33_sel", 32'(bus.sel), 32'hF);
    step(1'b0, 4'b0000, "r33_after");
    check("r33_pulsos", 32'(n_pulsos), 32'd1);

    // Press on the last idle cycle wins, in both wait states.
    step(1'b1, 4'b0000, "r34_ini");
    repeat (TIMEOUT - 1) step(1'b0, 4'b0000, "r34_idle_n");
    step(1'b0, 4'b0001, "r34_niv");
    check("r34_no_to_n", 32'(bus.timeout), 32'd0);
    check("r34_estado_n", 32'(bus.db_estado), 32'(ST_REGISTRA_NIVEL));
    step(1'b0, 4'b0000, "r34_rn");
    repeat (TIMEOUT - 1) step(1'b0, 4'b0000, "r34_idle_m");
    step(1'b0, 4'b0010, "r34_mem");
    check("r34_no_to_m", 32'(bus.timeout), 32'd0);
    step(1'b0, 4'b0000, "r34_fim");
    check("r34_sel", 32'(bus.sel), 32'h1);

    // Asynchronous reset while waiting for memory, then a clean sequence.
    step(1'b1, 4'b0000, "r35_ini");
    step(1'b0, 4'b0001, "r35_niv");
    step(1'b0, 4'b0000, "r35_rn");
    check("r35_em", 32'(bus.db_estado), 32'(ST_ESPERA_MEMORIA));
    async_reset("r35_rst");
    check("r35_rst_estado", 32'(bus.db_estado), 32'(ST_INICIAL));
    check("r35_rst_sel", 32'(bus.sel), 32'hF);
    step(1'b1, 4'b0000, "r35_ini2");
    step(1'b0, 4'b0001, "r35_niv2");
    step(1'b0, 4'b0000, "r35_rn2");
    step(1'b0, 4'b0100, "r35_mem2");
    step(1'b0, 4'b0000, "r35_fim2");
    check("r35_sel", 32'(bus.sel), 32'h2);

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset("rnd_rst");
      end else begin
        ini = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 9))
          0, 1:    bot = 4'(1 << $urandom_range(0, 3));
          2:       bot = 4'($urandom_range(1, 15));
          default: bot = 4'b0000;
        endcase
        step(ini, bot, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seletor_modo.md
SELETOR_MODO -- requirements
Module: seletor_modo

Interface
REQ-001 Parameter TIMEOUT, default 5000, SHALL set the idle cycles allowed in a wait state before abort; legal range 2..65535.
REQ-002 clock  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; it SHALL force the reset state immediately, independent of clock.
REQ-004 iniciar  input  1  single-cycle pulse that starts a new configuration.
REQ-005 botoes  input  4  single-cycle, edge-detected button pulses; bit i selects option i.
REQ-006 sel  output  4  registered mode code {nivel, memoria}; values 0..11 are valid, 4'b1111 is invalid.
REQ-007 nivel  output  2  registered level: 00 easy, 01 medium, 10 hard.
REQ-008 memoria  output  2  registered memory: 00 easy, 01 medium, 10 hard, 11 custom.
REQ-009 pronto  output  1  high while sel holds a valid confirmed code.
REQ-010 timeout  output  1  one-cycle pulse when a wait state aborts.
REQ-011 db_estado  output  3  current state code, for debug.

Function
REQ-012 The FSM SHALL have these states: INICIAL, ESPERA_NIVEL, REGISTRA_NIVEL, ESPERA_MEMORIA, REGISTRA_MEMORIA, PRONTO.
REQ-013 INICIAL SHALL go to ESPERA_NIVEL on iniciar=1; otherwise it SHALL stay in INICIAL.
REQ-014 In ESPERA_NIVEL, a one-hot botoes value in {0001, 0010, 0100} SHALL go to REGISTRA_NIVEL on the next edge; any other value, including 1000, multi-hot or zero, SHALL be ignored.
REQ-015 REGISTRA_NIVEL SHALL load nivel with the index of the pressed bit and go to ESPERA_MEMORIA unconditionally after 1 cycle.
REQ-016 In ESPERA_MEMORIA, any one-hot botoes value SHALL go to REGISTRA_MEMORIA; multi-hot or zero values SHALL be ignored.
REQ-017 REGISTRA_MEMORIA SHALL load memoria with the index of the pressed bit and go to PRONTO after 1 cycle.
REQ-018 On entry to PRONTO, sel SHALL equal {nivel, memoria} and pronto SHALL be 1, both registered in the same cycle.
REQ-019 Latency: memory press in cycle n -> pronto=1 in cycle n+2.
REQ-020 In PRONTO, iniciar=1 SHALL go to ESPERA_NIVEL, clear pronto and set sel=4'b1111 on the same edge; botoes SHALL be ignored in PRONTO.
REQ-021 In both wait states, a timeout counter SHALL count cycles with no accepted press and clear on each state entry.
REQ-022 When the count reaches TIMEOUT-1, the FSM SHALL go to INICIAL, pulse timeout for 1 cycle and set sel=4'b1111.
REQ-023 If a valid press and the timeout occur in the same cycle, the press SHALL win and no timeout pulse SHALL be issued.
REQ-024 iniciar in any state other than INICIAL or PRONTO SHALL be ignored.
REQ-025 Whenever pronto=0, sel SHALL be 4'b1111, so a downstream selector outputs all-ones.

Reset
REQ-026 On reset the block SHALL set state=INICIAL, sel=4'b1111, nivel=00, memoria=00, pronto=0, timeout=0 and counter=0.
REQ-027 Reset asserted mid-configuration SHALL discard the partial selection; the first iniciar after release SHALL start cleanly.

Structure
REQ-028 A shared package SHALL hold the state encodings (3 bits), SEL_INVALID=4'b1111 and the level and memory code constants.
REQ-029 The timeout counter SHALL be a sub-module contador_timeout (ports: clock, reset, zera, conta, fim; parameter M).
REQ-030 The remaining logic SHALL be a single FSM with a registered datapath in seletor_modo.

Verification (TIMEOUT=8)
REQ-031 Reset, then iniciar, botoes=0010, then botoes=1000 -> pronto=1, sel=4'b0111 two cycles after the second press.
REQ-032 In ESPERA_NIVEL, botoes=1000, then 0011, then 0100, then memory 0001 -> the first two presses are ignored; sel=4'b1000.
REQ-033 iniciar, then no press for 8 cycles -> timeout pulses once, db_estado=INICIAL, sel=4'b1111, pronto=0.
REQ-034 Press on exactly the 8th idle cycle -> accepted; no timeout pulse.
REQ-035 Reset asserted asynchronously in ESPERA_MEMORIA mid-cycle -> outputs go to reset values before the next edge; a new sequence 0001/0100 then gives sel=4'b0010.
REQ-036 In PRONTO with sel=4'b1011, apply iniciar -> next cycle sel=4'b1111, pronto=0, db_estado=ESPERA_NIVEL.
